// File: rtl/flex_hub_pkg.sv
// flex_hub_pkg: shared types and helpers for the flex peripheral read-back hub.
//   wd_state_e      watchdog FSM states
//   TIMEOUT_PATTERN read word synthesised on watchdog expiry
//                   (only with FLEX_HUB_TIMEOUT_DTACK_EN)
//   timeout_fill    TIMEOUT_PATTERN replicated across 1024 bits
//                   (the caller truncates it)
//   lowest_set      index of the lowest set bit of a 32-bit vector
//   multi_set       1 when two or more bits of a 32-bit vector are set
package flex_hub_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, EXPIRE, DONE} wd_state_e;

  localparam logic [15:0] TIMEOUT_PATTERN = 16'hDEAD;

  function automatic logic [1023:0] timeout_fill();
    logic [1023:0] r;
    r = '0;
    for (int unsigned b = 0; b < 1024; b++) r[b] = TIMEOUT_PATTERN[b % 16];
    return r;
  endfunction

  function automatic logic [4:0] lowest_set(input logic [31:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) if (v[i]) idx = 5'(i);
    return idx;
  endfunction

  // Clearing the lowest set bit leaves something only if a second bit was set.
  function automatic logic multi_set(input logic [31:0] v);
    return (v & (v - 32'd1)) != '0;
  endfunction

endpackage

// File: rtl/flex_hub_pipe_if.sv
// flex_hub_pipe_if: bus between the SCU slave macro / flex peripheral array
// and the read-back hub.
//   slave modport  : the hub's view (slave-side inputs in, merged results out)
//   master modport : the environment's view (drives requests and slave returns)
// Signals: ext_req, clr_status, sec_data_r[NR_SLAVES*W], sec_dtack[NR_SLAVES],
//   sec_data_r_act[NR_SLAVES], data_r[W], dtack, data_r_act, collision,
//   collision_mask[NR_SLAVES], collision_cnt[CNT_WIDTH], timeout,
//   timeout_sticky.
interface flex_hub_pipe_if #(
  parameter int unsigned DATA_BUS_WIDTH = 16,
  parameter int unsigned NR_SLAVES      = 4,
  parameter int unsigned CNT_WIDTH      = 8
);
  logic                                ext_req;
  logic                                clr_status;
  logic [NR_SLAVES*DATA_BUS_WIDTH-1:0] sec_data_r;
  logic [NR_SLAVES-1:0]                sec_dtack;
  logic [NR_SLAVES-1:0]                sec_data_r_act;
  logic [DATA_BUS_WIDTH-1:0]           data_r;
  logic                                dtack;
  logic                                data_r_act;
  logic                                collision;
  logic [NR_SLAVES-1:0]                collision_mask;
  logic [CNT_WIDTH-1:0]                collision_cnt;
  logic                                timeout;
  logic                                timeout_sticky;

  modport slave (
    input  ext_req, clr_status, sec_data_r, sec_dtack, sec_data_r_act,
    output data_r, dtack, data_r_act, collision, collision_mask,
           collision_cnt, timeout, timeout_sticky
  );

  modport master (
    output ext_req, clr_status, sec_data_r, sec_dtack, sec_data_r_act,
    input  data_r, dtack, data_r_act, collision, collision_mask,
           collision_cnt, timeout, timeout_sticky
  );
endinterface

// File: rtl/flex_hub_watchdog.sv
// flex_hub_watchdog: per-access dtack watchdog.
//   clock, reset  : clock, synchronous active-high reset
//   ext_req       : master access pending (level)
//   any_dtack     : OR of all slave dtacks
//   timeout       : registered one-cycle pulse, the cycle after EXPIRE
//   expire_dtack  : high while in EXPIRE (aligns with timeout once registered
//                   by the caller)
module flex_hub_watchdog
  import flex_hub_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clock,
  input  logic reset,
  input  logic ext_req,
  input  logic any_dtack,
  output logic timeout,
  output logic expire_dtack
);
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  wd_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          timeout_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= (state_q == EXPIRE);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (ext_req) begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        cnt_d = cnt_q + 1'b1;
        // dtack outranks both abort and expiry on the same cycle
        if (any_dtack)          state_d = DONE;
        else if (!ext_req)      state_d = IDLE;
        else if (cnt_q == LAST) state_d = EXPIRE;
      end
      EXPIRE: state_d = DONE;
      DONE:   if (!ext_req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign timeout      = timeout_q;
  assign expire_dtack = (state_q == EXPIRE);
endmodule

// File: rtl/flex_hub_pipe.sv
// flex_hub_pipe: registered read-back hub merging NR_SLAVES flex peripherals
// into one SCU-bus-facing set, with collision status and a dtack watchdog.
//   clock, reset : clock, synchronous active-high reset
//   bus (slave)  : ext_req/clr_status/sec_* in; data_r, dtack, data_r_act,
//                  collision, collision_mask, collision_cnt, timeout,
//                  timeout_sticky out (all registered, 1-cycle latency)
// Build option: define FLEX_HUB_TIMEOUT_DTACK_EN to have the hub answer an
// expired access itself with dtack and TIMEOUT_PATTERN for one cycle.
module flex_hub_pipe
  import flex_hub_pkg::*;
#(
  parameter int unsigned DATA_BUS_WIDTH = 16,
  parameter int unsigned NR_SLAVES      = 4,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input logic           clock,
  input logic           reset,
  flex_hub_pipe_if.slave bus
);
  logic [31:0]               act_vec;
  logic [4:0]                sel_idx;
  logic [DATA_BUS_WIDTH-1:0] sel_data;
  logic                      any_dtack, coll, expire, wd_timeout;

  logic [DATA_BUS_WIDTH-1:0] data_d, data_q;
  logic                      dtack_d, dtack_q, act_q, coll_q;
  logic [NR_SLAVES-1:0]      mask_d, mask_q;
  logic [CNT_WIDTH-1:0]      cnt_d, cnt_q;
  logic                      sticky_d, sticky_q;

  assign any_dtack = |bus.sec_dtack;
  assign coll      = multi_set(act_vec);

  always_comb begin
    act_vec                = '0;
    act_vec[NR_SLAVES-1:0] = bus.sec_data_r_act;
    sel_idx                = lowest_set(act_vec);
    sel_data               = '0;
    for (int unsigned i = 0; i < NR_SLAVES; i++)
      if (bus.sec_data_r_act[i] && (sel_idx == 5'(i)))
        sel_data = bus.sec_data_r[i*DATA_BUS_WIDTH +: DATA_BUS_WIDTH];
  end

  flex_hub_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clock       (clock),
    .reset       (reset),
    .ext_req     (bus.ext_req),
    .any_dtack   (any_dtack),
    .timeout     (wd_timeout),
    .expire_dtack(expire)
  );

`ifdef FLEX_HUB_TIMEOUT_DTACK_EN
  localparam logic [1023:0] PAT_WIDE = timeout_fill();
  localparam logic [DATA_BUS_WIDTH-1:0] TO_PAT = PAT_WIDE[DATA_BUS_WIDTH-1:0];
`endif

  always_comb begin
`ifdef FLEX_HUB_TIMEOUT_DTACK_EN
    dtack_d = any_dtack | expire;
    data_d  = expire ? TO_PAT : sel_data;
`else
    dtack_d = any_dtack;
    data_d  = sel_data;
`endif
    // Clear first, then apply this cycle's event, so a collision coinciding
    // with clr_status restarts the status at mask=act, count=1.
    mask_d = mask_q;
    cnt_d  = cnt_q;
    if (bus.clr_status) begin
      mask_d = '0;
      cnt_d  = '0;
    end
    if (coll) begin
      mask_d = mask_d | bus.sec_data_r_act;
      cnt_d  = (cnt_d == '1) ? cnt_d : cnt_d + 1'b1;
    end
    sticky_d = expire | (sticky_q & ~bus.clr_status);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      data_q   <= '0;
      dtack_q  <= 1'b0;
      act_q    <= 1'b0;
      coll_q   <= 1'b0;
      mask_q   <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      dtack_q  <= dtack_d;
      act_q    <= |bus.sec_data_r_act;
      coll_q   <= coll;
      mask_q   <= mask_d;
      cnt_q    <= cnt_d;
      sticky_q <= sticky_d;
    end
  end

  assign bus.data_r         = data_q;
  assign bus.dtack          = dtack_q;
  assign bus.data_r_act     = act_q;
  assign bus.collision      = coll_q;
  assign bus.collision_mask = mask_q;
  assign bus.collision_cnt  = cnt_q;
  assign bus.timeout        = wd_timeout;
  assign bus.timeout_sticky = sticky_q;
endmodule

// File: tb/tb_flex_hub_pipe.sv
module tb_flex_hub_pipe;
  localparam int unsigned W    = 16;
  localparam int unsigned N    = 4;
  localparam int unsigned T    = 8;
  localparam int unsigned CW   = 2;
  localparam int unsigned CMAX = (1 << CW) - 1;

  logic clock;
  logic reset;

  flex_hub_pipe_if #(.DATA_BUS_WIDTH(W), .NR_SLAVES(N), .CNT_WIDTH(CW)) bus ();

  flex_hub_pipe #(
    .DATA_BUS_WIDTH(W), .NR_SLAVES(N), .TIMEOUT_CYCLES(T), .CNT_WIDTH(CW)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  logic [W-1:0] m_data;
  logic         m_act, m_dtack, m_coll, m_to, m_sticky;
  logic [N-1:0] m_mask;
  int unsigned  m_cnt;
  // access tracking: live = outstanding without answer, settled = answered
  // or expired and waiting for ext_req low, fire = expiry declared
  bit           acc_live, acc_settled, fire;
  int unsigned  edge_no, acc_start;

  function automatic void model_edge();
    logic [N-1:0] a;
    logic [W-1:0] sel;
    bit           dt;
    bit           ext;
    bit           clr;
    a   = bus.sec_data_r_act;
    dt  = |bus.sec_dtack;
    ext = bus.ext_req;
    clr = bus.clr_status;
    edge_no++;
    if (reset) begin
      m_data = '0; m_act = 0; m_dtack = 0; m_coll = 0; m_to = 0; m_sticky = 0;
      m_mask = '0; m_cnt = 0;
      acc_live = 0; acc_settled = 0; fire = 0;
      return;
    end
    sel = '0;
    for (int i = N - 1; i >= 0; i--) if (a[i]) sel = bus.sec_data_r[i*W +: W];
    m_act   = |a;
    m_data  = sel;
    m_dtack = dt;
    m_coll  = ($countones(a) >= 2);
    if (m_coll) begin
      m_mask = clr ? a : (m_mask | a);
      m_cnt  = clr ? 1 : ((m_cnt >= CMAX) ? CMAX : m_cnt + 1);
    end else if (clr) begin
      m_mask = '0;
      m_cnt  = 0;
    end
    m_to     = fire;
    m_sticky = fire | (m_sticky & !clr);
`ifdef FLEX_HUB_TIMEOUT_DTACK_EN
    if (fire) begin
      m_dtack = 1;
      m_data  = 16'hDEAD;
    end
`endif
    if (fire) begin
      fire = 0;
      acc_settled = 1;
    end else if (acc_settled) begin
      if (!ext) acc_settled = 0;
    end else if (acc_live) begin
      if (dt) begin
        acc_live = 0; acc_settled = 1;
      end else if (!ext) begin
        acc_live = 0;
      end else if (edge_no - acc_start == T) begin
        acc_live = 0; fire = 1;
      end
    end else if (ext) begin
      acc_live = 1;
      acc_start = edge_no;
    end
  endfunction

  task automatic compare_model();
    check("m_data_r", bus.data_r, m_data);
    check("m_data_r_act", bus.data_r_act, m_act);
    check("m_dtack", bus.dtack, m_dtack);
    check("m_collision", bus.collision, m_coll);
    check("m_mask", bus.collision_mask, m_mask);
    check("m_cnt", bus.collision_cnt, m_cnt);
    check("m_timeout", bus.timeout, m_to);
    check("m_sticky", bus.timeout_sticky, m_sticky);
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    compare_model();
  endtask

  task automatic idle_inputs();
    bus.ext_req = 0; bus.clr_status = 0; bus.sec_data_r = '0;
    bus.sec_dtack = '0; bus.sec_data_r_act = '0;
  endtask

  task automatic clear_status();
    bus.clr_status = 1;
    step();
    bus.clr_status = 0;
  endtask

  typedef struct {
    logic [N-1:0]   act;
    logic [N-1:0]   dt;
    logic [N*W-1:0] data;
    logic [W-1:0]   exp_data;
    logic           exp_act;
    logic           exp_dtack;
    logic           exp_coll;
  } vec_t;

  vec_t tbl[6];

  initial begin
    tbl[0] = '{4'b0100, 4'b0000, {16'h0, 16'h1234, 16'h0, 16'h0},          16'h1234, 1, 0, 0};
    tbl[1] = '{4'b0000, 4'b0000, {16'h7777, 16'h6666, 16'h5555, 16'h4444}, 16'h0000, 0, 0, 0};
    tbl[2] = '{4'b0001, 4'b0001, {16'h7777, 16'h6666, 16'h5555, 16'h4444}, 16'h4444, 1, 1, 0};
    tbl[3] = '{4'b1000, 4'b0000, {16'hBEEF, 16'h6666, 16'h5555, 16'h4444}, 16'hBEEF, 1, 0, 0};
    tbl[4] = '{4'b0000, 4'b0100, {16'hBEEF, 16'h6666, 16'h5555, 16'h4444}, 16'h0000, 0, 1, 0};
    tbl[5] = '{4'b1100, 4'b0000, {16'h3333, 16'h2222, 16'h5555, 16'h4444}, 16'h2222, 1, 0, 1};

    reset = 1;
    idle_inputs();
    step();
    step();
    check("rst_data_r", bus.data_r, 0);
    check("rst_dtack", bus.dtack, 0);
    check("rst_timeout", bus.timeout, 0);
    check("rst_cnt", bus.collision_cnt, 0);
    reset = 0;
    step();

    // table vectors
    for (int unsigned k = 0; k < 6; k++) begin
      bus.sec_data_r_act = tbl[k].act;
      bus.sec_dtack      = tbl[k].dt;
      bus.sec_data_r     = tbl[k].data;
      step();
      check($sformatf("tbl%0d_data_r", k), bus.data_r, tbl[k].exp_data);
      check($sformatf("tbl%0d_act", k), bus.data_r_act, tbl[k].exp_act);
      check($sformatf("tbl%0d_dtack", k), bus.dtack, tbl[k].exp_dtack);
      check($sformatf("tbl%0d_coll", k), bus.collision, tbl[k].exp_coll);
    end
    idle_inputs();
    clear_status();

    // three collision cycles, then clear
    bus.sec_data_r_act = 4'b1010;
    bus.sec_data_r     = {16'hBBBB, 16'h0, 16'hAAAA, 16'h0};
    for (int unsigned k = 1; k <= 3; k++) begin
      step();
      check("c3_data_r", bus.data_r, 16'hAAAA);
      check("c3_pulse", bus.collision, 1);
      check("c3_cnt_run", bus.collision_cnt, k);
    end
    bus.sec_data_r_act = '0;
    step();
    check("c3_mask", bus.collision_mask, 4'b1010);
    check("c3_cnt", bus.collision_cnt, 3);
    check("c3_no_pulse", bus.collision, 0);
    clear_status();
    check("clr_mask", bus.collision_mask, 0);
    check("clr_cnt", bus.collision_cnt, 0);
    check("clr_sticky", bus.timeout_sticky, 0);

    // saturation, then collision coincident with clear
    bus.sec_data_r_act = 4'b0111;
    for (int unsigned k = 0; k < 5; k++) step();
    check("sat_cnt", bus.collision_cnt, CMAX);
    bus.sec_data_r_act = 4'b0011;
    bus.clr_status = 1;
    step();
    bus.clr_status = 0;
    check("clrcoll_mask", bus.collision_mask, 4'b0011);
    check("clrcoll_cnt", bus.collision_cnt, 1);
    idle_inputs();
    clear_status();

    // watchdog expiry: timeout 9 cycles after the first sampling edge
    bus.ext_req = 1;
    step();
    for (int unsigned k = 1; k <= T + 1; k++) begin
      step();
      check($sformatf("to_pulse_k%0d", k), bus.timeout, (k == T + 1) ? 1 : 0);
      if (k == T + 1) begin
        check("to_sticky", bus.timeout_sticky, 1);
`ifdef FLEX_HUB_TIMEOUT_DTACK_EN
        check("to_dtack", bus.dtack, 1);
        check("to_data", bus.data_r, 16'hDEAD);
`else
        check("to_dtack", bus.dtack, 0);
        check("to_data", bus.data_r, 0);
`endif
      end
    end
    step();
    check("to_pulse_end", bus.timeout, 0);
    check("to_sticky_hold", bus.timeout_sticky, 1);
    bus.ext_req = 0;
    step();
    clear_status();
    check("to_sticky_clr", bus.timeout_sticky, 0);

    // dtack arriving on the last counted cycle wins over expiry
    bus.ext_req = 1;
    step();
    for (int unsigned k = 1; k < T; k++) step();
    bus.sec_dtack = 4'b1000;
    step();
    check("late_dtack_out", bus.dtack, 1);
    check("late_dtack_no_to", bus.timeout, 0);
    bus.sec_dtack = '0;
    for (int unsigned k = 0; k < 3 * T; k++) begin
      step();
      check("done_hold_no_to", bus.timeout, 0);
    end
    bus.ext_req = 0;
    step();

    // reset mid-access, then a fresh window
    bus.ext_req = 1;
    step();
    for (int unsigned k = 1; k <= 5; k++) step();
    reset = 1;
    step();
    check("midrst_timeout", bus.timeout, 0);
    check("midrst_dtack", bus.dtack, 0);
    reset = 0;
    step();
    for (int unsigned k = 1; k <= T + 1; k++) begin
      step();
      check($sformatf("rst_win_k%0d", k), bus.timeout, (k == T + 1) ? 1 : 0);
    end
    idle_inputs();
    step();
    clear_status();

    // randomized traffic against the model
    for (int unsigned c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 11) == 0) bus.ext_req = ~bus.ext_req;
      bus.sec_data_r_act = ($urandom_range(0, 1) == 0) ? 4'b0 : 4'($urandom_range(0, 15));
      bus.sec_dtack      = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(1, 15)) : 4'b0;
      bus.sec_data_r     = {$urandom, $urandom};
      bus.clr_status     = ($urandom_range(0, 15) == 0);
      reset              = ($urandom_range(0, 299) == 0);
      step();
    end
    reset = 0;
    idle_inputs();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
